sha256_compress: RTL

SHA-256 compression engine that sits directly downstream of the padding preprocessor. It consumes padded 512-bit blocks flagged by `tick` (intermediate block) or `final_block` (last block of a message). It runs the 64-round compression one round per clock and accumulates the chaining value H0..H7. At the end of each message it presents the 256-bit digest; its `done` output feeds back to the preprocessor.

---
 rtl/sha256_compress.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/sha256_compress.sv
// SHA-256 compression engine: one round per clock, 66-cycle block period.
// Holds the chaining value across intermediate blocks and publishes the
// digest after the last block of each message, then reloads the IV.
module sha256_compress (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         final_block,
    input  logic [511:0] msg_padded,
    output logic         ready,
    output logic         done,
    output logic [255:0] digest,
    output logic         digest_valid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ROUND  = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    logic [1:0]  state;
    logic [5:0]  t;
    logic        last;
    logic [31:0] h_reg [8];
    logic [31:0] wv    [8];
    logic [31:0] w     [16];

    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] w_next;
    logic [31:0] h_sum [8];

    assign ready = (state == ST_IDLE);

    // Round datapath: T1/T2, next schedule word and the chaining sums.
    always_comb begin
        t1 = wv[7]
           + (rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25))
           + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6]))
           + K[t]
           + w[0];
        t2 = (rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22))
           + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
        w_next = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
        for (int i = 0; i < 8; i++) begin
            h_sum[i] = h_reg[i] + wv[i];
        end
    end

    // Control FSM plus working-variable, schedule and chaining registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            t            <= 6'd0;
            last         <= 1'b0;
            done         <= 1'b0;
            digest_valid <= 1'b0;
            digest       <= 256'd0;
            for (int i = 0; i < 8; i++) begin
                h_reg[i] <= IV[i];
                wv[i]    <= 32'd0;
            end
            for (int i = 0; i < 16; i++) begin
                w[i] <= 32'd0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (tick || final_block) begin
                        for (int i = 0; i < 16; i++) begin
                            w[i] <= msg_padded[511 - 32*i -: 32];
                        end
                        for (int i = 0; i < 8; i++) begin
                            wv[i] <= h_reg[i];
                        end
                        t            <= 6'd0;
                        last         <= final_block;
                        digest_valid <= 1'b0;
                        state        <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    wv[7] <= wv[6];
                    wv[6] <= wv[5];
                    wv[5] <= wv[4];
                    wv[4] <= wv[3] + t1;
                    wv[3] <= wv[2];
                    wv[2] <= wv[1];
                    wv[1] <= wv[0];
                    wv[0] <= t1 + t2;
                    for (int i = 0; i < 15; i++) begin
                        w[i] <= w[i+1];
                    end
                    w[15] <= w_next;
                    if (t == 6'd63) begin
                        state <= ST_UPDATE;
                    end else begin
                        t <= t + 6'd1;
                    end
                end
                ST_UPDATE: begin
                    done <= 1'b1;
                    if (last) begin
                        digest       <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3],
                                         h_sum[4], h_sum[5], h_sum[6], h_sum[7]};
                        digest_valid <= 1'b1;
                        for (int i = 0; i < 8; i++) begin
                            h_reg[i] <= IV[i];
                        end
                    end else begin
                        for (int i = 0; i < 8; i++) begin
                            h_reg[i] <= h_sum[i];
                        end
                    end
                    t     <= 6'd0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
